// File: rtl/mul_share_arb_if.sv
// Handshake bundle for mul_share_arb: two request channels,
// two response channels, plus busy and ops_done status.
interface mul_share_arb_if #(
  parameter int BIT = 8
);
  logic           req0_valid;
  logic           req0_ready;
  logic [BIT-1:0] req0_a;
  logic [BIT-1:0] req0_b;
  logic           req1_valid;
  logic           req1_ready;
  logic [BIT-1:0] req1_a;
  logic [BIT-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [2*BIT-1:0] rsp0_data;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [2*BIT-1:0] rsp1_data;

  logic        busy;
  logic [15:0] ops_done;

  modport master (
    output req0_valid, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_a, req1_b,
    input  req1_ready,
    input  rsp0_valid, rsp0_data,
    output rsp0_ready,
    input  rsp1_valid, rsp1_data,
    output rsp1_ready,
    input  busy, ops_done
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_a, req1_b,
    output req1_ready,
    output rsp0_valid, rsp0_data,
    input  rsp0_ready,
    output rsp1_valid, rsp1_data,
    input  rsp1_ready,
    output busy, ops_done
  );
endinterface

// File: rtl/mul_share_arb.sv
// Two-channel round-robin front end sharing one 8x8 multiplier.
// Ports: clock, rst_n (async low), bus (mul_share_arb_if.slave).
module mul_share_arb #(
  parameter int BIT = 8
) (
  input logic           clock,
  input logic           rst_n,
  mul_share_arb_if.slave bus
);
  logic             s1_valid;
  logic             s1_tag;
  logic [BIT-1:0]   s1_a;
  logic [BIT-1:0]   s1_b;
  logic             rsp0_valid;
  logic             rsp1_valid;
  logic [2*BIT-1:0] rsp0_data;
  logic [2*BIT-1:0] rsp1_data;
  logic [2*BIT-1:0] prod;
  logic             last_grant;
  logic [15:0]      ops_done;

  logic hs0, hs1;
  logic elig0, elig1;
  logic grant0, grant1;

  DADDA_8x8_42 u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // A channel may issue only if its response slot will be
  // free when the product lands, and it is not already in S1.
  always_comb begin
    hs0   = rsp0_valid & bus.rsp0_ready;
    hs1   = rsp1_valid & bus.rsp1_ready;
    elig0 = bus.req0_valid
          & ~(s1_valid & ~s1_tag)
          & (~rsp0_valid | hs0);
    elig1 = bus.req1_valid
          & ~(s1_valid & s1_tag)
          & (~rsp1_valid | hs1);
    grant0 = rst_n & elig0
           & (~elig1 | last_grant);
    grant1 = rst_n & elig1
           & (~elig0 | ~last_grant);
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_tag     <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
      last_grant <= 1'b1;
      ops_done   <= '0;
    end else begin
      s1_valid <= grant0 | grant1;
      if (grant0 | grant1) begin
        s1_tag     <= grant1;
        s1_a       <= grant1 ? bus.req1_a : bus.req0_a;
        s1_b       <= grant1 ? bus.req1_b : bus.req0_b;
        last_grant <= grant1;
      end
      // A landing product wins over a same-edge drain.
      if (s1_valid && !s1_tag) begin
        rsp0_valid <= 1'b1;
        rsp0_data  <= prod;
      end else if (hs0) begin
        rsp0_valid <= 1'b0;
      end
      if (s1_valid && s1_tag) begin
        rsp1_valid <= 1'b1;
        rsp1_data  <= prod;
      end else if (hs1) begin
        rsp1_valid <= 1'b0;
      end
      ops_done <= ops_done + 16'(hs0) + 16'(hs1);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = rsp0_valid;
  assign bus.rsp1_valid = rsp1_valid;
  assign bus.rsp0_data  = rsp0_data;
  assign bus.rsp1_data  = rsp1_data;
  assign bus.busy       = s1_valid | rsp0_valid | rsp1_valid;
  assign bus.ops_done   = ops_done;
endmodule

// Unsigned 8x8 multiplier core: partial-product accumulation,
// exact 16-bit result.
module DADDA_8x8_42 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p + ({8'h00, a} << i);
    end
  end
endmodule

// File: tb/tb_mul_share_arb.sv
// Randomised self-checking bench for mul_share_arb with a
// per-channel FIFO reference model.
module tb_mul_share_arb;
  logic clock;
  logic rst_n;
  int   checks = 0;
  int   passed = 0;

  mul_share_arb_if #(.BIT(8)) bus ();

  mul_share_arb #(.BIT(8)) dut (
    .clock (clock),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.req0_valid = 0;
    bus.req0_a     = 0;
    bus.req0_b     = 0;
    bus.req1_valid = 0;
    bus.req1_a     = 0;
    bus.req1_b     = 0;
    bus.rsp0_ready = 1;
    bus.rsp1_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst_n = 0;
    idle();
    @(negedge clock);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    bus.req0_valid = 1;
    bus.req0_a = 5;
    bus.req0_b = 6;
    bus.rsp0_ready = 1;
    @(negedge clock);
    bus.req0_valid = 0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (bus.ops_done !== 16'd1)
      $display("FAIL rst_pre_ops: got %0d want 1",
               bus.ops_done);
    else passed++;
    bus.req0_valid = 1;
    bus.req0_a = 7;
    bus.req0_b = 9;
    bus.rsp0_ready = 0;
    @(negedge clock);
    bus.req0_valid = 0;
    @(negedge clock);
    checks++;
    if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== 16'd63)
      $display("FAIL rst_pre_rsp: got %b/%0d want 1/63",
               bus.rsp0_valid, bus.rsp0_data);
    else passed++;
    #2;
    rst_n = 0;
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    #1;
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0)
      $display("FAIL rst_valid: got %b%b want 00",
               bus.rsp0_valid, bus.rsp1_valid);
    else passed++;
    checks++;
    if (bus.rsp0_data !== 16'd0 || bus.rsp1_data !== 16'd0)
      $display("FAIL rst_data: got %0d/%0d want 0/0",
               bus.rsp0_data, bus.rsp1_data);
    else passed++;
    checks++;
    if (bus.busy !== 1'b0 || bus.ops_done !== 16'd0)
      $display("FAIL rst_busy_ops: got %b/%0d want 0/0",
               bus.busy, bus.ops_done);
    else passed++;
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL rst_ready: got %b%b want 00",
               bus.req0_ready, bus.req1_ready);
    else passed++;
    @(negedge clock);
    checks++;
    if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0)
      $display("FAIL rst_ready_hold: got %b%b want 00",
               bus.req0_ready, bus.req1_ready);
    else passed++;
    idle();
    rst_n = 1;
  endtask

  task automatic test_single();
    @(negedge clock);
    bus.req0_valid = 1;
    bus.req0_a = 13;
    bus.req0_b = 11;
    bus.rsp0_ready = 0;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1)
      $display("FAIL single_accept: got %b want 1",
               bus.req0_ready);
    else passed++;
    @(negedge clock);
    bus.req0_valid = 0;
    checks++;
    if (bus.rsp0_valid !== 1'b0)
      $display("FAIL single_early: got %b want 0",
               bus.rsp0_valid);
    else passed++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (bus.rsp0_valid !== 1'b1 ||
          bus.rsp0_data !== 16'd143)
        $display("FAIL single_hold%0d: got %b/%0d want 1/143",
                 i, bus.rsp0_valid, bus.rsp0_data);
      else passed++;
    end
    bus.rsp0_ready = 1;
    @(negedge clock);
    checks++;
    if (bus.rsp0_valid !== 1'b0 || bus.ops_done !== 16'd1)
      $display("FAIL single_drain: got %b/%0d want 0/1",
               bus.rsp0_valid, bus.ops_done);
    else passed++;
  endtask

  task automatic test_tie();
    logic e0;
    do_reset();
    @(negedge clock);
    bus.req0_valid = 1;
    bus.req0_a = 255;
    bus.req0_b = 255;
    bus.req1_valid = 1;
    bus.req1_a = 0;
    bus.req1_b = 7;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      e0 = (i % 2 == 0);
      checks++;
      if (bus.req0_ready !== e0 || bus.req1_ready !== !e0)
        $display("FAIL tie_grant%0d: got %b%b want %b%b",
                 i, bus.req0_ready, bus.req1_ready, e0, !e0);
      else passed++;
      if (i == 2) begin
        checks++;
        if (bus.rsp0_valid !== 1'b1 ||
            bus.rsp0_data !== 16'd65025)
          $display("FAIL tie_rsp0: got %b/%0d want 1/65025",
                   bus.rsp0_valid, bus.rsp0_data);
        else passed++;
      end
      if (i == 3) begin
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 16'd0)
          $display("FAIL tie_rsp1: got %b/%0d want 1/0",
                   bus.rsp1_valid, bus.rsp1_data);
        else passed++;
      end
    end
    idle();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [15:0] q[$];
    logic [15:0] exp;
    int acc = 0;
    idle();
    bus.rsp1_ready = 0;
    @(negedge clock);
    bus.req1_valid = 1;
    bus.req1_a = 3;
    bus.req1_b = 4;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1)
      $display("FAIL bp_first: got %b want 1", bus.req1_ready);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      bus.req1_a = 5;
      bus.req1_b = 6;
      bus.req0_valid = 1;
      bus.req0_a = 8'($urandom);
      bus.req0_b = 8'($urandom);
      #1;
      checks++;
      if (bus.req1_ready !== 1'b0)
        $display("FAIL bp_req1_ready%0d: got %b want 0",
                 i, bus.req1_ready);
      else passed++;
      if (bus.req0_ready) begin
        acc++;
        q.push_back(16'(bus.req0_a) * 16'(bus.req0_b));
      end
      if (bus.rsp0_valid && q.size() > 0) begin
        exp = q.pop_front();
        checks++;
        if (bus.rsp0_data !== exp)
          $display("FAIL bp_rsp0: got %0d want %0d",
                   bus.rsp0_data, exp);
        else passed++;
      end
    end
    checks++;
    if (acc !== 4)
      $display("FAIL bp_rate: got %0d want 4", acc);
    else passed++;
    @(negedge clock);
    bus.req0_valid = 0;
    bus.rsp1_ready = 1;
    #1;
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 16'd12 ||
        bus.req1_ready !== 1'b1)
      $display("FAIL bp_drain: got %b/%0d/%b want 1/12/1",
               bus.rsp1_valid, bus.rsp1_data, bus.req1_ready);
    else passed++;
    if (bus.rsp0_valid && q.size() > 0) begin
      exp = q.pop_front();
      checks++;
      if (bus.rsp0_data !== exp)
        $display("FAIL bp_rsp0_last: got %0d want %0d",
                 bus.rsp0_data, exp);
      else passed++;
    end
    @(negedge clock);
    bus.req1_valid = 0;
    @(negedge clock);
    checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 16'd30)
      $display("FAIL bp_second: got %b/%0d want 1/30",
               bus.rsp1_valid, bus.rsp1_data);
    else passed++;
    checks++;
    if (q.size() !== 0)
      $display("FAIL bp_lost: got %0d pending want 0", q.size());
    else passed++;
    idle();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_midop();
    idle();
    @(negedge clock);
    bus.req1_valid = 1;
    bus.req1_a = 9;
    bus.req1_b = 9;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1)
      $display("FAIL midop_accept: got %b want 1",
               bus.req1_ready);
    else passed++;
    @(negedge clock);
    bus.req1_valid = 0;
    #1 rst_n = 0;
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0)
        $display("FAIL midop_ghost%0d: got %b/%b want 0/0",
                 i, bus.rsp1_valid, bus.busy);
      else passed++;
    end
    bus.req0_valid = 1;
    bus.req1_valid = 1;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL midop_tie: got %b%b want 10",
               bus.req0_ready, bus.req1_ready);
    else passed++;
    @(negedge clock);
    idle();
    repeat (4) @(negedge clock);
  endtask

  task automatic test_random();
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] exp;
    logic [15:0] pd0, pd1;
    logic pv0, pr0, pv1, pr1;
    int sent0 = 0, sent1 = 0, got0 = 0, got1 = 0;
    int cyc = 0, hs = 0;
    do_reset();
    pv0 = 0; pr0 = 0; pv1 = 0; pr1 = 0;
    pd0 = 0; pd1 = 0;
    while ((got0 < 1000 || got1 < 1000) && cyc < 30000) begin
      @(negedge clock);
      cyc++;
      if (pv0 && !pr0) begin
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== pd0)
          $display("FAIL rnd_hold0: got %b/%0d want 1/%0d",
                   bus.rsp0_valid, bus.rsp0_data, pd0);
        else passed++;
      end
      if (pv1 && !pr1) begin
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== pd1)
          $display("FAIL rnd_hold1: got %b/%0d want 1/%0d",
                   bus.rsp1_valid, bus.rsp1_data, pd1);
        else passed++;
      end
      checks++;
      if (bus.ops_done !== 16'(hs))
        $display("FAIL rnd_ops: got %0d want %0d",
                 bus.ops_done, 16'(hs));
      else passed++;
      bus.req0_valid = (sent0 < 1000) && ($urandom_range(9) < 7);
      bus.req1_valid = (sent1 < 1000) && ($urandom_range(9) < 7);
      bus.req0_a = 8'($urandom);
      bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom);
      bus.req1_b = 8'($urandom);
      bus.rsp0_ready = ($urandom_range(9) < 6);
      bus.rsp1_ready = ($urandom_range(9) < 6);
      #1;
      checks++;
      if (bus.req0_ready && bus.req1_ready)
        $display("FAIL rnd_onegrant: got 11 want at most one");
      else passed++;
      if (bus.req0_valid && bus.req0_ready) begin
        q0.push_back(16'(bus.req0_a) * 16'(bus.req0_b));
        sent0++;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        q1.push_back(16'(bus.req1_a) * 16'(bus.req1_b));
        sent1++;
      end
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        got0++;
        hs++;
        checks++;
        if (q0.size() == 0)
          $display("FAIL rnd_rsp0: got %0d want none pending",
                   bus.rsp0_data);
        else begin
          exp = q0.pop_front();
          if (bus.rsp0_data !== exp)
            $display("FAIL rnd_rsp0: got %0d want %0d",
                     bus.rsp0_data, exp);
          else passed++;
        end
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        got1++;
        hs++;
        checks++;
        if (q1.size() == 0)
          $display("FAIL rnd_rsp1: got %0d want none pending",
                   bus.rsp1_data);
        else begin
          exp = q1.pop_front();
          if (bus.rsp1_data !== exp)
            $display("FAIL rnd_rsp1: got %0d want %0d",
                     bus.rsp1_data, exp);
          else passed++;
        end
      end
      pv0 = bus.rsp0_valid;
      pr0 = bus.rsp0_ready;
      pd0 = bus.rsp0_data;
      pv1 = bus.rsp1_valid;
      pr1 = bus.rsp1_ready;
      pd1 = bus.rsp1_data;
    end
    checks++;
    if (got0 < 1000 || got1 < 1000)
      $display("FAIL rnd_timeout: got %0d/%0d want 1000/1000",
               got0, got1);
    else passed++;
    idle();
    @(negedge clock);
    checks++;
    if (bus.ops_done !== 16'd2000 || bus.busy !== 1'b0)
      $display("FAIL rnd_final: got %0d/%b want 2000/0",
               bus.ops_done, bus.busy);
    else passed++;
  endtask

  initial begin
    clock = 0;
    rst_n = 0;
    idle();
    repeat (2) @(negedge clock);
    rst_n = 1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
